// File: rtl/pc_sequencer.sv
// Program-counter stage: registers the selected next PC, drives PC+4 back to the mux,
// flushes IF/ID on redirects and freezes in TRAP on bad targets. Optional: PC_REDIRECT_CNT_EN.
//   state | meaning
//   RUN   | loading NewPC every edge
//   STALL | hazard hold, PC frozen, redirect not latched
//   TRAP  | misaligned target or invalid select seen; only reset exits
module pc_sequencer #(
  parameter int unsigned      NBits        = 32,
  parameter logic [NBits-1:0] RESET_VECTOR = 32'h0040_0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NBits-1:0] NewPC,
  input  logic [1:0]       PCSrc,
  input  logic             Stall,
  output logic [NBits-1:0] PCValue,
  output logic [NBits-1:0] PCPlus4,
  output logic             Flush,
  output logic             Misaligned,
  output logic [1:0]       State
`ifdef PC_REDIRECT_CNT_EN
  ,
  output logic [15:0]      RedirectCount
`endif
);

  localparam logic [1:0] ST_RUN   = 2'b00;
  localparam logic [1:0] ST_STALL = 2'b01;
  localparam logic [1:0] ST_TRAP  = 2'b10;

  localparam logic [1:0] SRC_SEQ     = 2'b00;
  localparam logic [1:0] SRC_BRANCH  = 2'b01;
  localparam logic [1:0] SRC_JUMP    = 2'b10;
  localparam logic [1:0] SRC_INVALID = 2'b11;

  localparam logic [NBits-1:0] FOUR = NBits'(4);

  logic [NBits-1:0] pc_q;
  logic [1:0]       state_q;
  logic             flush_q;
  logic             mis_q;
  logic             bad_target;
  logic             redirect;
  logic             load_ok;

  assign bad_target = (PCSrc == SRC_INVALID) || (NewPC[1:0] != 2'b00);
  assign redirect   = (PCSrc == SRC_BRANCH) || (PCSrc == SRC_JUMP);
  // An accepted load: not trapped, not stalled, target legal.
  assign load_ok    = (state_q != ST_TRAP) && !Stall && !bad_target;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_VECTOR;
      state_q <= ST_RUN;
      flush_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_TRAP: begin
          flush_q <= 1'b0;
          mis_q   <= 1'b1;
        end
        default: begin
          if (Stall) begin
            state_q <= ST_STALL;
            flush_q <= 1'b0;
          end else if (bad_target) begin
            state_q <= ST_TRAP;
            mis_q   <= 1'b1;
            flush_q <= 1'b0;
          end else begin
            pc_q    <= NewPC;
            state_q <= ST_RUN;
            flush_q <= redirect;
          end
        end
      endcase
    end
  end

`ifdef PC_REDIRECT_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 16'h0000;
    end else if (load_ok && redirect && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'h0001;
    end
  end

  assign RedirectCount = cnt_q;
`endif

  assign PCValue    = pc_q;
  assign PCPlus4    = pc_q + FOUR;
  assign Flush      = flush_q;
  assign Misaligned = mis_q;
  assign State      = state_q;

  logic unused_src_seq;
  assign unused_src_seq = (PCSrc == SRC_SEQ) & load_ok;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: per-edge expectations from a reference model go
// into a queue at drive time and are popped and checked one edge later.
module tb_pc_sequencer;

  localparam logic [31:0] RV = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] NewPC;
  logic [1:0]  PCSrc;
  logic        Stall;
  logic [31:0] PCValue;
  logic [31:0] PCPlus4;
  logic        Flush;
  logic        Misaligned;
  logic [1:0]  State;
`ifdef PC_REDIRECT_CNT_EN
  logic [15:0] RedirectCount;
`endif

  pc_sequencer #(.NBits(32), .RESET_VECTOR(RV)) dut (
    .clk(clk),
    .reset(reset),
    .NewPC(NewPC),
    .PCSrc(PCSrc),
    .Stall(Stall),
    .PCValue(PCValue),
    .PCPlus4(PCPlus4),
    .Flush(Flush),
    .Misaligned(Misaligned),
    .State(State)
`ifdef PC_REDIRECT_CNT_EN
    ,
    .RedirectCount(RedirectCount)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic        flush;
    logic        mis;
    logic [1:0]  st;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int failures = 0;

  // reference model state
  logic [31:0] m_pc;
  logic [1:0]  m_st;
  logic        m_flush;
  logic        m_mis;
  logic [15:0] m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step(input logic rst, input logic stl, input logic [1:0] src,
                      input logic [31:0] npc);
    exp_t e;
    reset = rst;
    Stall = stl;
    PCSrc = src;
    NewPC = npc;
    if (rst) begin
      m_pc = RV; m_st = 2'b00; m_flush = 1'b0; m_mis = 1'b0; m_cnt = 16'h0;
    end else if (m_st == 2'b10) begin
      m_flush = 1'b0;
    end else if (stl) begin
      m_st = 2'b01; m_flush = 1'b0;
    end else if (src == 2'b11 || npc[1:0] != 2'b00) begin
      m_st = 2'b10; m_mis = 1'b1; m_flush = 1'b0;
    end else begin
      m_pc = npc; m_st = 2'b00;
      m_flush = (src == 2'b01 || src == 2'b10);
      if (m_flush && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'h1;
    end
    e.pc = m_pc; e.flush = m_flush; e.mis = m_mis; e.st = m_st; e.cnt = m_cnt;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = exp_q.pop_front();
      check("pc", PCValue, e.pc);
      check("pcplus4", PCPlus4, e.pc + 32'd4);
      check("flush", {31'b0, Flush}, {31'b0, e.flush});
      check("misaligned", {31'b0, Misaligned}, {31'b0, e.mis});
      check("state", {30'b0, State}, {30'b0, e.st});
`ifdef PC_REDIRECT_CNT_EN
      check("redirect_count", {16'b0, RedirectCount}, {16'b0, e.cnt});
`endif
    end
  endtask

  initial begin
    reset = 1'b1; Stall = 1'b0; PCSrc = 2'b00; NewPC = 32'h0;
    m_pc = RV; m_st = 2'b00; m_flush = 1'b0; m_mis = 1'b0; m_cnt = 16'h0;
    #2;

    // reset
    step(1'b1, 1'b0, 2'b00, 32'h0);
    step(1'b1, 1'b0, 2'b01, 32'h0040_0800);
    check("reset_pc", PCValue, 32'h0040_0000);

    // sequential steps
    step(1'b0, 1'b0, 2'b00, m_pc + 32'd4);
    step(1'b0, 1'b0, 2'b00, m_pc + 32'd4);
    step(1'b0, 1'b0, 2'b00, m_pc + 32'd4);
    check("seq_pc3", PCValue, 32'h0040_000C);

    // branch, then sequential clears flush
    step(1'b0, 1'b0, 2'b01, 32'h0040_0100);
    check("branch_pc", PCValue, 32'h0040_0100);
    check("branch_flush", {31'b0, Flush}, 32'd1);
    step(1'b0, 1'b0, 2'b00, m_pc + 32'd4);
    check("after_branch_flush", {31'b0, Flush}, 32'd0);

    // stalled jump is not latched, loads on the edge stall drops
    step(1'b0, 1'b1, 2'b10, 32'h0040_0200);
    step(1'b0, 1'b1, 2'b10, 32'h0040_0200);
    check("stall_hold_pc", PCValue, 32'h0040_0104);
    check("stall_state", {30'b0, State}, 32'd1);
    step(1'b0, 1'b0, 2'b10, 32'h0040_0200);
    check("unstall_pc", PCValue, 32'h0040_0200);
    check("unstall_flush", {31'b0, Flush}, 32'd1);

    // back-to-back jumps keep flush high
    step(1'b0, 1'b0, 2'b10, 32'h0040_0300);
    step(1'b0, 1'b0, 2'b10, 32'h0040_0300);
    check("b2b_flush", {31'b0, Flush}, 32'd1);
    // stall right after a redirect drops flush
    step(1'b0, 1'b1, 2'b00, 32'h0040_0304);
    check("stall_flush_low", {31'b0, Flush}, 32'd0);
    // stall outranks a misaligned target
    step(1'b0, 1'b1, 2'b01, 32'h0040_0302);
    step(1'b0, 1'b0, 2'b00, m_pc + 32'd4);

    // wrap to zero is a legal sequential load
    step(1'b0, 1'b0, 2'b10, 32'hFFFF_FFFC);
    check("wrap_pcplus4", PCPlus4, 32'h0000_0000);
    step(1'b0, 1'b0, 2'b00, m_pc + 32'd4);
    check("wrap_pc", PCValue, 32'h0000_0000);
    check("wrap_state", {30'b0, State}, 32'd0);

    // misaligned branch traps; trap ignores everything but reset
    step(1'b0, 1'b0, 2'b00, 32'h0040_0000);
    step(1'b0, 1'b0, 2'b01, 32'h0040_0102);
    check("trap_state", {30'b0, State}, 32'd2);
    check("trap_pc", PCValue, 32'h0040_0000);
    step(1'b0, 1'b1, 2'b10, 32'h0040_0500);
    step(1'b0, 1'b0, 2'b10, 32'h0040_0500);
    step(1'b0, 1'b0, 2'b00, 32'h0040_0004);
    check("trap_frozen_pc", PCValue, 32'h0040_0000);
    step(1'b1, 1'b1, 2'b10, 32'h0040_0500);
    check("trap_reset_mis", {31'b0, Misaligned}, 32'd0);

    // invalid select traps even with aligned target
    step(1'b0, 1'b0, 2'b00, m_pc + 32'd4);
    step(1'b0, 1'b0, 2'b11, 32'h0040_0400);
    check("invalid_trap", {30'b0, State}, 32'd2);
    check("invalid_pc", PCValue, 32'h0040_0004);

    // reset mid-stall
    step(1'b1, 1'b0, 2'b00, 32'h0);
    step(1'b0, 1'b1, 2'b01, 32'h0040_0600);
    step(1'b1, 1'b1, 2'b01, 32'h0040_0600);
    check("stall_reset_state", {30'b0, State}, 32'd0);

`ifdef PC_REDIRECT_CNT_EN
    // 3 redirects, 1 stalled redirect, 2 sequential steps
    step(1'b0, 1'b0, 2'b01, 32'h0040_0010);
    step(1'b0, 1'b0, 2'b10, 32'h0040_0020);
    step(1'b0, 1'b1, 2'b10, 32'h0040_0030);
    step(1'b0, 1'b0, 2'b01, 32'h0040_0040);
    step(1'b0, 1'b0, 2'b00, m_pc + 32'd4);
    step(1'b0, 1'b0, 2'b00, m_pc + 32'd4);
    check("count_three", {16'b0, RedirectCount}, 32'd3);
    for (int i = 0; i < 65540; i++) begin
      reset = 1'b0; Stall = 1'b0; PCSrc = 2'b10; NewPC = 32'h0040_0080;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'h1;
      m_pc = 32'h0040_0080; m_flush = 1'b1; m_st = 2'b00;
      @(posedge clk);
      #1;
    end
    check("count_saturate", {16'b0, RedirectCount}, 32'h0000_FFFF);
    step(1'b0, 1'b0, 2'b01, 32'h0040_0090);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
